// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-to-execute handshake bundle for pipeline_hazard_ctrl.
// The master drives the decoded instruction; the slave (controller) returns pass/advance/hazard.
interface pipeline_hazard_ctrl_if;
    logic       i_valid;
    logic [4:0] i_src_a;
    logic       i_src_a_en;
    logic [4:0] i_src_b;
    logic       i_src_b_en;
    logic [4:0] i_dst1;
    logic       i_dst1_en;
    logic [4:0] i_dst2;
    logic       i_dst2_en;
    logic       i_is_branch;
    logic       i_is_load;
    logic       ext_stall;
    logic       d_pass;
    logic       d_pcincr;
    logic       o_hazard;

    modport master (
        output i_valid, i_src_a, i_src_a_en, i_src_b, i_src_b_en,
        output i_dst1, i_dst1_en, i_dst2, i_dst2_en, i_is_branch, i_is_load, ext_stall,
        input  d_pass, d_pcincr, o_hazard
    );

    modport slave (
        input  i_valid, i_src_a, i_src_a_en, i_src_b, i_src_b_en,
        input  i_dst1, i_dst1_en, i_dst2, i_dst2_en, i_is_branch, i_is_load, ext_stall,
        output d_pass, d_pcincr, o_hazard
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard controller: DEPTH-entry write scoreboard, RAW/branch/external stalls.
// Optional macro HAZARD_FWD_EN: only a load in the newest entry can cause a hazard.
module pipeline_hazard_ctrl #(
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned BR_BUBBLES = 2,
    parameter int unsigned CNTW       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave bus,
    output logic [31:0]           o_busy_mask,
    output logic [CNTW-1:0]       o_bubble_cnt
);
    localparam int unsigned BrW = (BR_BUBBLES > 1) ? $clog2(BR_BUBBLES + 1) : 1;

    typedef struct packed {
        logic [4:0] dst1;
        logic       en1;
        logic [4:0] dst2;
        logic       en2;
        logic       load;
    } sb_entry_t;

    typedef enum logic [0:0] {StRun, StBranch} state_e;

    sb_entry_t        r_sb [DEPTH];
    state_e           r_state;
    logic [BrW-1:0]   r_br_cnt;
    logic [CNTW-1:0]  r_bubble_cnt;

    sb_entry_t        w_new;
    logic             w_match_a;
    logic             w_match_b;
    logic             w_hazard_raw;
    logic             w_run;
    logic             w_issue;
    logic [31:0]      w_busy;

    function automatic logic f_match(input logic [4:0] src, input logic en, input sb_entry_t e);
        return en && (src != 5'd0) && ((e.en1 && (e.dst1 == src)) || (e.en2 && (e.dst2 == src)));
    endfunction

    always_comb begin
        w_match_a = 1'b0;
        w_match_b = 1'b0;
`ifdef HAZARD_FWD_EN
        // ALU results are forwarded; only a load still in flight one stage ahead blocks.
        if (r_sb[0].load) begin
            w_match_a = f_match(bus.i_src_a, bus.i_src_a_en, r_sb[0]);
            w_match_b = f_match(bus.i_src_b, bus.i_src_b_en, r_sb[0]);
        end
`else
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_match_a |= f_match(bus.i_src_a, bus.i_src_a_en, r_sb[k]);
            w_match_b |= f_match(bus.i_src_b, bus.i_src_b_en, r_sb[k]);
        end
`endif
    end

    assign w_new        = {bus.i_dst1, bus.i_dst1_en, bus.i_dst2, bus.i_dst2_en, bus.i_is_load};
    assign w_run        = (r_state == StRun) && !rst;
    assign w_hazard_raw = bus.i_valid && (w_match_a || w_match_b);
    assign w_issue      = w_run && bus.i_valid && !w_hazard_raw && !bus.ext_stall;

    assign bus.d_pass   = w_issue;
    assign bus.d_pcincr = w_run && !bus.ext_stall && !w_hazard_raw;
    assign bus.o_hazard = w_run && w_hazard_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_sb[k] <= '0;
            end
        end else begin
            r_sb[0] <= w_issue ? w_new : '0;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                r_sb[k] <= r_sb[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StRun;
            r_br_cnt <= '0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_issue && bus.i_is_branch && (BR_BUBBLES != 0)) begin
                        r_state  <= StBranch;
                        r_br_cnt <= BrW'(BR_BUBBLES);
                    end
                end
                StBranch: begin
                    if (!bus.ext_stall) begin
                        r_br_cnt <= r_br_cnt - BrW'(1);
                        if (r_br_cnt == BrW'(1)) begin
                            r_state <= StRun;
                        end
                    end
                end
                default: r_state <= StRun;
            endcase
        end
    end

    always_comb begin
        w_busy = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (r_sb[k].en1) w_busy[r_sb[k].dst1] = 1'b1;
            if (r_sb[k].en2) w_busy[r_sb[k].dst2] = 1'b1;
        end
        w_busy[0] = 1'b0;
    end

    assign o_busy_mask = w_busy;

    // Count only bubbles that displaced real work: a held instruction or a branch shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_cnt <= '0;
        end else if (!bus.d_pass && (bus.i_valid || (r_state == StBranch))
                     && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + CNTW'(1);
        end
    end

    assign o_bubble_cnt = r_bubble_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a cycle-stamp reference model predicts every
// cycle's outputs; a separate monitor pops and compares. A CNTW=4 copy exercises saturation.
module tb_pipeline_hazard_ctrl;
    localparam int unsigned DEPTH  = 3;
    localparam int unsigned BR     = 2;
    localparam int unsigned CNTW   = 16;
    localparam int unsigned CNTW_S = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if bus ();
    pipeline_hazard_ctrl_if bus_s ();

    logic [31:0]       busy;
    logic [31:0]       busy_s;
    logic [CNTW-1:0]   bub;
    logic [CNTW_S-1:0] bub_s;

    pipeline_hazard_ctrl #(.DEPTH(DEPTH), .BR_BUBBLES(BR), .CNTW(CNTW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .o_busy_mask  (busy),
        .o_bubble_cnt (bub)
    );

    pipeline_hazard_ctrl #(.DEPTH(DEPTH), .BR_BUBBLES(BR), .CNTW(CNTW_S)) dut_s (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_s),
        .o_busy_mask  (busy_s),
        .o_bubble_cnt (bub_s)
    );

    typedef struct {
        logic rst, valid;
        logic [4:0] sa; logic sae;
        logic [4:0] sb; logic sbe;
        logic [4:0] d1; logic d1e;
        logic [4:0] d2; logic d2e;
        logic br, ld, stall;
    } stim_t;

    typedef struct {
        logic pass, pcincr, hazard;
        bit known;
        logic [31:0] busy;
        longint bub, bub_s;
        string tag;
    } exp_t;

    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;

    // Reference model: a register is pending when its latest writer issued 1..DEPTH cycles ago.
    longint cyc = 0;
    longint last_wr[32];
    longint last_ld[32];
    int     br_left = 0;
    longint m_bub = 0, m_bub_s = 0;
    bit     known = 0;

    function automatic bit pending(input logic [4:0] r);
        return (r != 0) && (cyc - last_wr[r] >= 1) && (cyc - last_wr[r] <= DEPTH);
    endfunction

    function automatic bit src_blocks(input logic [4:0] r, input logic en);
        if (!en || r == 0) return 1'b0;
`ifdef HAZARD_FWD_EN
        return last_ld[r] == cyc - 1;
`else
        return pending(r);
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic apply(input stim_t s);
        rst = s.rst;
        bus.i_valid = s.valid;     bus_s.i_valid = s.valid;
        bus.i_src_a = s.sa;        bus_s.i_src_a = s.sa;
        bus.i_src_a_en = s.sae;    bus_s.i_src_a_en = s.sae;
        bus.i_src_b = s.sb;        bus_s.i_src_b = s.sb;
        bus.i_src_b_en = s.sbe;    bus_s.i_src_b_en = s.sbe;
        bus.i_dst1 = s.d1;         bus_s.i_dst1 = s.d1;
        bus.i_dst1_en = s.d1e;     bus_s.i_dst1_en = s.d1e;
        bus.i_dst2 = s.d2;         bus_s.i_dst2 = s.d2;
        bus.i_dst2_en = s.d2e;     bus_s.i_dst2_en = s.d2e;
        bus.i_is_branch = s.br;    bus_s.i_is_branch = s.br;
        bus.i_is_load = s.ld;      bus_s.i_is_load = s.ld;
        bus.ext_stall = s.stall;   bus_s.ext_stall = s.stall;
    endtask

    // Called #1 after a posedge: drive, predict, push, then advance the model at the next edge.
    task automatic drive(input stim_t s, input string tag);
        exp_t e;
        bit   hz;
        apply(s);
        hz = s.valid && (src_blocks(s.sa, s.sae) || src_blocks(s.sb, s.sbe));
        e.tag = tag;
        e.known = known;
        e.bub = m_bub;
        e.bub_s = m_bub_s;
        e.busy = '0;
        for (int r = 1; r < 32; r++) e.busy[r] = pending(5'(r));
        if (s.rst || br_left > 0) begin
            e.pass = 0; e.pcincr = 0; e.hazard = 0;
        end else begin
            e.hazard = hz;
            e.pass   = s.valid && !hz && !s.stall;
            e.pcincr = !s.stall && !hz;
        end
        q.push_back(e);
        @(posedge clk);
        if (s.rst) begin
            for (int r = 0; r < 32; r++) begin
                last_wr[r] = -1000;
                last_ld[r] = -1000;
            end
            br_left = 0; m_bub = 0; m_bub_s = 0; known = 1;
        end else begin
            if (!e.pass && (s.valid || br_left > 0)) begin
                if (m_bub < (64'd1 << CNTW) - 1) m_bub++;
                if (m_bub_s < (64'd1 << CNTW_S) - 1) m_bub_s++;
            end
            if (e.pass) begin
                if (s.d1e) begin last_wr[s.d1] = cyc; if (s.ld) last_ld[s.d1] = cyc; end
                if (s.d2e) begin last_wr[s.d2] = cyc; if (s.ld) last_ld[s.d2] = cyc; end
            end
            if (br_left > 0) begin
                if (!s.stall) br_left--;
            end else if (e.pass && s.br && BR > 0) begin
                br_left = BR;
            end
        end
        cyc++;
        #1;
    endtask

    function automatic stim_t ins(input bit v, input logic [4:0] sa, input bit sae,
                                  input logic [4:0] sb, input bit sbe,
                                  input logic [4:0] d1, input bit d1e,
                                  input bit br = 0, input bit ld = 0, input bit stall = 0);
        stim_t s;
        s.rst = 0; s.valid = v; s.sa = sa; s.sae = sae; s.sb = sb; s.sbe = sbe;
        s.d1 = d1; s.d1e = d1e; s.d2 = 5'd0; s.d2e = 0; s.br = br; s.ld = ld; s.stall = stall;
        return s;
    endfunction

    function automatic stim_t rst_stim();
        stim_t s;
        s = ins(0, 0, 0, 0, 0, 0, 0);
        s.rst = 1;
        return s;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.tag, ".d_pass"},   64'(bus.d_pass),   64'(e.pass));
                chk({e.tag, ".d_pcincr"}, 64'(bus.d_pcincr), 64'(e.pcincr));
                chk({e.tag, ".o_hazard"}, 64'(bus.o_hazard), 64'(e.hazard));
                if (e.known) begin
                    chk({e.tag, ".busy_mask"},  64'(busy),  64'(e.busy));
                    chk({e.tag, ".bubble_cnt"}, 64'(bub),   64'(e.bub));
                    chk({e.tag, ".bubble_sat"}, 64'(bub_s), 64'(e.bub_s));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin : stimulus
        stim_t s;
        apply(rst_stim());
        @(posedge clk); #1;
        drive(rst_stim(), "reset");
        drive(rst_stim(), "reset");

        for (int i = 1; i <= 5; i++) drive(ins(1, 0, 1, 0, 1, 5'(i), 1), "indep");
        for (int i = 0; i < 4; i++) drive(ins(0, 0, 0, 0, 0, 0, 0), "drain");

        drive(ins(1, 1, 1, 0, 0, 5, 1), "raw_prod");
        for (int i = 0; i < 4; i++) drive(ins(1, 5, 1, 0, 0, 9, 0), "raw_cons");
        for (int i = 0; i < 4; i++) drive(ins(0, 0, 0, 0, 0, 0, 0), "drain");

        drive(ins(1, 1, 1, 0, 0, 7, 1), "alu_r7");
        for (int i = 0; i < 4; i++) drive(ins(1, 7, 1, 0, 0, 0, 0), "alu_use");
        for (int i = 0; i < 4; i++) drive(ins(0, 0, 0, 0, 0, 0, 0), "drain");
        drive(ins(1, 1, 1, 0, 0, 7, 1, 0, 1), "load_r7");
        for (int i = 0; i < 4; i++) drive(ins(1, 0, 0, 7, 1, 0, 0), "load_use");
        for (int i = 0; i < 4; i++) drive(ins(0, 0, 0, 0, 0, 0, 0), "drain");

        drive(ins(1, 0, 0, 0, 0, 0, 0, 1), "branch");
        drive(ins(1, 1, 1, 0, 0, 2, 1, 0, 0, 0), "br_shadow");
        drive(ins(1, 1, 1, 0, 0, 2, 1, 0, 0, 1), "br_stall");
        drive(ins(1, 1, 1, 0, 0, 2, 1, 0, 0, 0), "br_shadow");
        drive(ins(1, 1, 1, 0, 0, 2, 1), "br_resume");
        for (int i = 0; i < 4; i++) drive(ins(0, 0, 0, 0, 0, 0, 0), "drain");

        drive(ins(1, 0, 1, 0, 1, 0, 1), "dst_r0");
        drive(ins(1, 0, 1, 0, 1, 3, 1), "r0_read");
        drive(ins(1, 3, 0, 3, 0, 4, 1), "src_dis");
        drive(ins(1, 3, 1, 0, 0, 0, 0), "src_en");

        drive(ins(1, 1, 1, 0, 0, 4, 1), "busy_r4");
        drive(ins(1, 0, 0, 0, 0, 0, 0, 1), "branch2");
        drive(ins(1, 4, 1, 0, 0, 0, 0), "in_branch");
        drive(rst_stim(), "mid_rst");
        drive(ins(1, 4, 1, 0, 0, 6, 1), "post_rst");
        drive(ins(0, 0, 0, 0, 0, 0, 0), "post_rst_idle");

        for (int i = 0; i < 20; i++) drive(ins(1, 0, 0, 0, 0, 0, 0, 0, 0, 1), "sat_stall");

        for (int i = 0; i < 3000; i++) begin
            s.rst   = ($urandom_range(63) == 0);
            s.valid = ($urandom_range(3) != 0);
            s.sa = 5'($urandom_range(7));  s.sae = 1'($urandom_range(1));
            s.sb = 5'($urandom_range(7));  s.sbe = 1'($urandom_range(1));
            s.d1 = 5'($urandom_range(7));  s.d1e = ($urandom_range(3) != 0);
            s.d2 = 5'($urandom_range(7));  s.d2e = ($urandom_range(3) == 0);
            s.br = ($urandom_range(7) == 0);
            s.ld = ($urandom_range(2) == 0);
            s.stall = ($urandom_range(4) == 0);
            drive(s, "random");
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
